// File: rtl/lbp_host_pkg.sv
// Shared defaults, FSM encoding and border test for the LBP host memory model.
package lbp_host_pkg;

    localparam int LBP_IMG_W  = 128;
    localparam int LBP_IMG_H  = 128;
    localparam int LBP_ADDR_W = 14;
    localparam int LBP_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } host_state_t;

    // True when a raster address lies on the outer ring of the image.
    function automatic logic is_border(input logic [31:0] addr, input int img_w, input int img_h);
        int a;
        a = int'(addr);
        return (a < img_w) || (a >= (img_h - 1) * img_w) ||
               ((a % img_w) == 0) || ((a % img_w) == img_w - 1);
    endfunction

endpackage

// File: rtl/lbp_img_ram.sv
// Image storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module lbp_img_ram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/lbp_host_mem.sv
// Host memory model for the LBP engine: load gray image, serve reads, capture results, dump them.
// Optional LBP_HOST_WRITE_CHECK_EN adds a sticky protocol-error flag on err.
module lbp_host_mem
    import lbp_host_pkg::*;
#(
    parameter int IMG_W  = lbp_host_pkg::LBP_IMG_W,
    parameter int IMG_H  = lbp_host_pkg::LBP_IMG_H,
    parameter int ADDR_W = lbp_host_pkg::LBP_ADDR_W,
    parameter int DATA_W = lbp_host_pkg::LBP_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic              gray_ready,
    output logic [DATA_W-1:0] gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    host_state_t       r_state;
    host_state_t       w_next_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_live;
    logic              w_load_hs;
    logic              w_dump_hs;
    logic              w_cnt_last;
    logic              w_res_wr;
    logic [DATA_W-1:0] w_gray_rd;
    logic [DATA_W-1:0] w_res_rd;

    // r_live holds load_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    assign w_load_hs  = (r_state == ST_LOAD) && r_live && load_valid;
    assign w_dump_hs  = (r_state == ST_DUMP) && dump_ready;
    assign w_cnt_last = (r_cnt == LAST_ADDR);
    assign w_res_wr   = (r_state == ST_SERVE) && lbp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        load_ready   = 1'b0;
        gray_ready   = 1'b0;
        gray_data    = '0;
        dump_valid   = 1'b0;
        dump_addr    = '0;
        dump_data    = '0;
        done         = 1'b0;
        case (r_state)
            ST_LOAD: begin
                load_ready = r_live;
                if (w_load_hs && w_cnt_last) begin
                    w_next_state = ST_SERVE;
                end
            end
            ST_SERVE: begin
                gray_ready = 1'b1;
                if (gray_req) begin
                    gray_data = w_gray_rd;
                end
                if (finish) begin
                    w_next_state = ST_DUMP;
                end
            end
            ST_DUMP: begin
                dump_valid = 1'b1;
                dump_addr  = r_cnt;
                // Border pixels were never computed by the engine, so mask stale RAM.
                if (!is_border(32'(r_cnt), IMG_W, IMG_H)) begin
                    dump_data = w_res_rd;
                end
                if (w_dump_hs && w_cnt_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
    end

    // One counter walks the image for both the load and dump phases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_load_hs || w_dump_hs) begin
            r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
    end

    lbp_img_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_gray_ram (
        .clk       (clk),
        .i_wr_en   (w_load_hs),
        .i_wr_addr (r_cnt),
        .i_wr_data (load_data),
        .i_rd_addr (gray_addr),
        .o_rd_data (w_gray_rd)
    );

    lbp_img_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_res_ram (
        .clk       (clk),
        .i_wr_en   (w_res_wr),
        .i_wr_addr (lbp_addr),
        .i_wr_data (lbp_data),
        .i_rd_addr (r_cnt),
        .o_rd_data (w_res_rd)
    );

`ifdef LBP_HOST_WRITE_CHECK_EN
    logic r_err;
    logic w_err_set;

    assign w_err_set = (lbp_valid && ((r_state != ST_SERVE) || is_border(32'(lbp_addr), IMG_W, IMG_H))) ||
                       (finish && (r_state == ST_LOAD));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed bench for lbp_host_mem with a per-cycle reference model and literal spot checks.
module tb_lbp_host_mem;

    localparam int W  = 128;
    localparam int H  = 128;
    localparam int N  = W * H;
    localparam int PL = 0, PS = 1, PD = 2, PDN = 3;
`ifdef LBP_HOST_WRITE_CHECK_EN
    localparam int CHK_EN = 1;
`else
    localparam int CHK_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_ready;
    logic        gray_req = 1'b0;
    logic [13:0] gray_addr = '0;
    logic        gray_ready;
    logic [7:0]  gray_data;
    logic        lbp_valid = 1'b0;
    logic [13:0] lbp_addr = '0;
    logic [7:0]  lbp_data = '0;
    logic        finish = 1'b0;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [13:0] dump_addr;
    logic [7:0]  dump_data;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    lbp_host_mem dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_ready (gray_ready),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .done       (done),
        .err        (err)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic bit brd(input int a);
        int row, col;
        row = a / W;
        col = a % W;
        return row == 0 || row == H - 1 || col == 0 || col == W - 1;
    endfunction

    // Reference model: image buffers plus phase and position within the current phase.
    logic [7:0] m_gray [N];
    logic [7:0] m_res  [N];
    bit         m_resk [N];
    int         m_ph   = PL;
    int         m_cnt  = 0;
    bit         m_live = 1'b0;
    bit         m_err  = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ph   <= PL;
            m_cnt  <= 0;
            m_live <= 1'b0;
            m_err  <= 1'b0;
        end else begin
            m_live <= 1'b1;
            if (CHK_EN != 0 &&
                ((lbp_valid && (m_ph != PS || brd(int'(lbp_addr)))) || (finish && m_ph == PL)))
                m_err <= 1'b1;
            if (m_ph == PL && m_live && load_valid) begin
                m_gray[m_cnt] <= load_data;
                m_cnt <= (m_cnt == N - 1) ? 0 : m_cnt + 1;
                if (m_cnt == N - 1) m_ph <= PS;
            end else if (m_ph == PS) begin
                if (lbp_valid) begin
                    m_res[lbp_addr]  <= lbp_data;
                    m_resk[lbp_addr] <= 1'b1;
                end
                if (finish) m_ph <= PD;
            end else if (m_ph == PD && dump_ready) begin
                m_cnt <= (m_cnt == N - 1) ? 0 : m_cnt + 1;
                if (m_cnt == N - 1) m_ph <= PDN;
            end
        end
    end

    bit cmp_on = 1'b1;

    always @(negedge clk) begin
        int e;
        #2;
        if (cmp_on) begin
            chk("load_ready", int'(load_ready), int'(m_ph == PL && m_live));
            chk("gray_ready", int'(gray_ready), int'(m_ph == PS));
            e = (m_ph == PS && gray_req) ? int'(m_gray[gray_addr]) : 0;
            chk("gray_data", int'(gray_data), e);
            chk("dump_valid", int'(dump_valid), int'(m_ph == PD));
            chk("dump_addr", int'(dump_addr), (m_ph == PD) ? m_cnt : 0);
            if (m_ph != PD || brd(m_cnt) || m_resk[m_cnt]) begin
                e = (m_ph == PD && !brd(m_cnt)) ? int'(m_res[m_cnt]) : 0;
                chk("dump_data", int'(dump_data), e);
            end
            chk("done", int'(done), int'(m_ph == PDN));
            chk("err", int'(err), int'(m_err));
        end
    end

    initial begin
        int idx, cyc, stalls, seen;
        bit lv, fin;

        // Reset values
        repeat (2) @(negedge clk);
        #3;
        chk("reset load_ready", int'(load_ready), 0);
        chk("reset done", int'(done), 0);
        chk("reset err", int'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        #3 chk("load_ready before first edge", int'(load_ready), 0);
        @(negedge clk);
        #3 chk("load_ready after release", int'(load_ready), 1);

        // Run A: first 256 pixels offered every other cycle, then back-to-back
        idx = 0;
        cyc = 0;
        while (idx < N) begin
            @(negedge clk);
            lv = (idx >= 256) || (cyc % 2 == 0);
            load_valid = lv;
            load_data  = 8'(idx * 7 + 3);
            if (lv) idx++;
            cyc++;
            if (idx == N && lv) begin
                #3 chk("gray_ready before last load", int'(gray_ready), 0);
            end
        end
        @(negedge clk);
        load_valid = 1'b0;
        #3 chk("gray_ready rise A", int'(gray_ready), 1);

        @(negedge clk);
        gray_req = 1'b1;
        gray_addr = 14'd1;
        #3 chk("gray second accepted", int'(gray_data), 10);
        @(negedge clk);
        gray_addr = 14'd0;
        #3 chk("gray first accepted", int'(gray_data), 3);
        @(negedge clk);
        gray_addr = 14'd300;
        #3 chk("gray 300 run A", int'(gray_data), 55);
        @(negedge clk);
        gray_req = 1'b0;
        #3 chk("gray_data no req", int'(gray_data), 0);

        // Border write in SERVE: flagged only when the checker is built in
        @(negedge clk);
        lbp_valid = 1'b1;
        lbp_addr  = 14'd0;
        lbp_data  = 8'h99;
        @(negedge clk);
        lbp_addr = 14'd130;
        lbp_data = 8'h11;
        #3 chk("err after border write", int'(err), CHK_EN);
        @(negedge clk);
        lbp_valid = 1'b0;
        #3 chk("err held", int'(err), CHK_EN);

        // Reset mid-SERVE
        @(negedge clk);
        reset = 1'b1;
        #3;
        chk("mid reset gray_ready", int'(gray_ready), 0);
        chk("mid reset load_ready", int'(load_ready), 0);
        chk("mid reset err", int'(err), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Run B: stray write and finish in LOAD must not disturb anything
        lbp_valid = 1'b1;
        lbp_addr  = 14'd130;
        lbp_data  = 8'h77;
        finish    = 1'b1;
        @(negedge clk);
        lbp_valid = 1'b0;
        finish    = 1'b0;
        #3;
        chk("still LOAD after finish", int'(load_ready), 1);
        chk("no serve after finish", int'(gray_ready), 0);

        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_data  = 8'(i);
            if (i == N - 1) begin
                #3 chk("gray_ready before last load B", int'(gray_ready), 0);
            end
        end
        @(negedge clk);
        load_valid = 1'b0;
        #3 chk("gray_ready rise B", int'(gray_ready), 1);
        @(negedge clk);
        gray_req = 1'b1;
        gray_addr = 14'd300;
        #3 chk("gray 300 run B", int'(gray_data), 44);
        @(negedge clk);
        gray_req = 1'b0;

        // Fill every interior result except the pinned addresses
        for (int a = 0; a < N; a++) begin
            if (!brd(a) && a != 129 && a != 130 && a != 16254) begin
                @(negedge clk);
                lbp_valid = 1'b1;
                lbp_addr  = 14'(a);
                lbp_data  = 8'(a * 3);
            end
        end
        @(negedge clk);
        lbp_addr = 14'd129;
        lbp_data = 8'hA5;
        @(negedge clk);
        lbp_addr = 14'd16254;
        lbp_data = 8'h3C;
        finish   = 1'b1;
        @(negedge clk);
        lbp_valid  = 1'b0;
        finish     = 1'b0;
        dump_ready = 1'b1;
        #3;
        chk("dump_valid after finish", int'(dump_valid), 1);
        chk("dump first addr", int'(dump_addr), 0);
        chk("dump addr 0 border", int'(dump_data), 0);

        stalls = 0;
        seen   = 0;
        fin    = 1'b0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            @(negedge clk);
            if (done) begin
                fin = 1'b1;
            end else begin
                if (dump_addr == 14'd200 && stalls < 5) begin
                    dump_ready = 1'b0;
                    stalls++;
                end else begin
                    dump_ready = 1'b1;
                end
                #3;
                if (!dump_ready) begin
                    chk("stall addr", int'(dump_addr), 200);
                    chk("stall data", int'(dump_data), 88);
                end else begin
                    case (int'(dump_addr))
                        127:   begin chk("dump 127", int'(dump_data), 0);     seen++; end
                        16256: begin chk("dump 16256", int'(dump_data), 0);   seen++; end
                        16383: begin chk("dump 16383", int'(dump_data), 0);   seen++; end
                        129:   begin chk("dump 129", int'(dump_data), 165);   seen++; end
                        130:   begin chk("dump 130", int'(dump_data), 17);    seen++; end
                        16254: begin chk("dump 16254", int'(dump_data), 60);  seen++; end
                        200:   begin chk("dump 200", int'(dump_data), 88);    seen++; end
                        default: ;
                    endcase
                end
            end
        end
        chk("dump completed in budget", int'(fin), 1);
        chk("pinned dump addresses seen", seen, 7);
        chk("stall cycles", stalls, 5);
        #3;
        chk("done set", int'(done), 1);
        chk("dump_valid off in done", int'(dump_valid), 0);
        dump_ready = 1'b0;
        repeat (3) @(negedge clk);
        #3 chk("done sticky", int'(done), 1);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lbp_host_mem.md
# lbp_host_mem

Host-side memory model and result collector for the LBP engine. Loads a 128x128 8-bit gray image from a pixel stream, then serves the engine's gray read port and captures its lbp write port. Once the engine signals finish, streams the full LBP result image back out in raster order. Sits opposite the LBP engine at chip/bench level, providing the other end of both of its memory interfaces.

## Interface
Parameters:
- IMG_W, 128, image width in pixels (power of two)
- IMG_H, 128, image height in pixels
- ADDR_W, 14, pixel address width; log2(IMG_W*IMG_H)
- DATA_W, 8, pixel width

Ports (reset is `reset`, asynchronous, active-high; clock is `clk`):
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- load_valid  in  1  load pixel present
- load_data  in  DATA_W  load pixel, raster order
- load_ready  out  1  block accepts load pixel
- gray_req  in  1  engine read request
- gray_addr  in  ADDR_W  engine read address
- gray_ready  out  1  image loaded, reads served
- gray_data  out  DATA_W  read data
- lbp_valid  in  1  engine result write strobe
- lbp_addr  in  ADDR_W  result write address
- lbp_data  in  DATA_W  result write data
- finish  in  1  engine done
- dump_valid  out  1  result pixel present
- dump_ready  in  1  consumer accepts result pixel
- dump_addr  out  ADDR_W  result pixel address
- dump_data  out  DATA_W  result pixel
- done  out  1  dump complete, sticky
- err  out  1  sticky protocol error (see Configuration)

## Operation
- FSM states: LOAD -> SERVE -> DUMP -> DONE; DONE held until reset.
- LOAD: load_ready=1. Handshake load_valid&load_ready writes gray RAM at load counter, counter+1. Handshake at counter IMG_W*IMG_H-1 -> SERVE.
- SERVE: gray_ready=1. gray_data = gray RAM[gray_addr] when gray_req, else 0. lbp_valid writes result RAM[lbp_addr]=lbp_data. finish=1 -> DUMP; an lbp_valid in the same cycle as finish is committed.
- lbp_valid outside SERVE: ignored, RAM unchanged.
- DUMP: dump counter 0..IMG_W*IMG_H-1; dump_valid=1, dump_addr=counter, dump_data=result RAM[counter], forced 0 for border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1). Counter advances on dump_valid&dump_ready; handshake at last address -> DONE.
- DONE: done=1, dump_valid=0, all other outputs at reset values.
- RAM contents not cleared by reset; border forcing makes dump output deterministic regardless.

## Timing
- Reset values: load_ready=0 (rises the first cycle after reset release, in LOAD), gray_ready=0, gray_data=0, dump_valid=0, dump_addr=0, dump_data=0, done=0, err=0; state LOAD, counters 0.
- Read latency zero: gray_data combinational from gray_addr, valid in the same cycle; engine registers addr at edge N, samples data at edge N+1.
- gray_ready rises the cycle after the final load handshake.
- Result write takes effect at the clk edge where lbp_valid=1; readable in DUMP thereafter.
- DUMP entered the cycle after finish is sampled; dump_valid high from that cycle; dump_addr/dump_data stable while dump_valid&!dump_ready.
- Back-to-back dump: one pixel per cycle with dump_ready held high; IMG_W*IMG_H cycles total.
- Reset mid-operation: immediate return to LOAD, counters 0, done/err cleared.

## Configuration
- LBP_HOST_WRITE_CHECK_EN defined: err set (sticky until reset) on any lbp_valid outside SERVE, any lbp_valid to a border address, or finish while state is LOAD.
- Undefined: err tied 0; no checker logic.

## Structure
- Package lbp_host_pkg: IMG_W, IMG_H, ADDR_W, DATA_W defaults, state enum, border-test function.
- Sub-module lbp_img_ram: one synchronous write port, one asynchronous read port; instantiated twice (gray, result).

## Test plan
- Load 16384 pixels with pixel value = addr[7:0], no stalls -> gray_ready rises the cycle after the 16384th handshake; gray_addr=300 reads 44.
- load_valid toggled every other cycle -> only handshaked pixels stored; gray_addr=1 reads second accepted pixel.
- SERVE: lbp_valid with lbp_addr=129, lbp_data=0xA5, then finish -> dump_addr=129 shows 0xA5; dump_addr 0, 127, 16256 show 0.
- lbp_valid with lbp_addr=16254, data=0x3C in the same cycle as finish -> dump shows 0x3C at 16254.
- dump_ready held low 5 cycles at dump_addr=200 -> addr/data stable; after final handshake done=1, dump_valid=0.
- With LBP_HOST_WRITE_CHECK_EN: lbp_valid at lbp_addr=0 in SERVE -> err=1 next cycle, held; reset -> err=0, state LOAD.
